// File: rtl/note_step_sequencer_if.sv
// Control, pattern-write and playback signals between a voice controller
// and one note_step_sequencer instance.
interface note_step_sequencer_if;
  logic       run;
  logic [3:0] last_step;
  logic [3:0] transpose;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_data;
  logic [3:0] note_out;
  logic       gate_out;
  logic [3:0] step_idx;
  logic       step_strobe;

  modport master (
    output run, last_step, transpose, wr_en, wr_addr, wr_data,
    input  note_out, gate_out, step_idx, step_strobe
  );

  modport slave (
    input  run, last_step, transpose, wr_en, wr_addr, wr_data,
    output note_out, gate_out, step_idx, step_strobe
  );
endinterface

// File: rtl/note_step_sequencer.sv
// 16-step programmable note sequencer for one voice: writable pattern,
// fixed tempo and gate length, loop length and transpose.
module note_step_sequencer #(
  parameter int STEP_CYCLES = 131072,
  parameter int GATE_CYCLES = 65536
) (
  input logic                  clk,
  input logic                  rst_n,
  note_step_sequencer_if.slave seq_if
);

  localparam int TICK_W = $clog2(STEP_CYCLES);
  localparam logic [TICK_W-1:0] GATE_END  = TICK_W'(GATE_CYCLES);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(STEP_CYCLES - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        step_q, step_d;
  logic [3:0]        note_q, note_d;
  logic              gate_q, gate_d;
  logic              strobe_q, strobe_d;
  logic [4:0]        pattern_q [16];
  logic [4:0]        pattern_d [16];
  logic [4:0]        entry;

  // The step entry is read from the current pattern before this edge's write lands.
  always_comb begin
    tick_d    = tick_q;
    step_d    = step_q;
    note_d    = note_q;
    gate_d    = gate_q;
    strobe_d  = 1'b0;
    pattern_d = pattern_q;
    entry     = pattern_q[step_q];

    if (seq_if.wr_en) begin
      pattern_d[seq_if.wr_addr] = seq_if.wr_data;
    end

    if (!seq_if.run) begin
      tick_d = '0;
      gate_d = 1'b0;
    end else if (tick_q == '0) begin
      note_d   = entry[3:0] + seq_if.transpose;
      gate_d   = ~entry[4];
      strobe_d = 1'b1;
      tick_d   = TICK_W'(1);
    end else begin
      if (tick_q == GATE_END) begin
        gate_d = 1'b0;
      end
      if (tick_q == LAST_TICK) begin
        tick_d = '0;
        step_d = (step_q >= seq_if.last_step) ? 4'd0 : step_q + 4'd1;
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q   <= '0;
      step_q   <= '0;
      note_q   <= '0;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        pattern_q[i] <= {1'b0, 4'(i)};
      end
    end else begin
      tick_q    <= tick_d;
      step_q    <= step_d;
      note_q    <= note_d;
      gate_q    <= gate_d;
      strobe_q  <= strobe_d;
      pattern_q <= pattern_d;
    end
  end

  assign seq_if.note_out    = note_q;
  assign seq_if.gate_out    = gate_q;
  assign seq_if.step_idx    = step_q;
  assign seq_if.step_strobe = strobe_q;

endmodule

// File: tb/tb_note_step_sequencer.sv
// Self-checking bench for note_step_sequencer: directed scenarios followed by
// randomized traffic, all checked against a step/elapsed-time reference model.
module tb_note_step_sequencer;
  localparam int STEP = 8;
  localparam int GATE = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  note_step_sequencer_if seqIf ();

  note_step_sequencer #(.STEP_CYCLES(STEP), .GATE_CYCLES(GATE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_if (seqIf.slave)
  );

  // Reference model: mElapsed counts cycles since the current step began
  // (-1 means no step sounding; the next run edge starts the held step).
  logic [4:0] mPat [16];
  int         mStep;
  int         mElapsed;
  int         mNote;
  logic       mRest;

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mPat[i] = {1'b0, 4'(i)};
    mStep    = 0;
    mElapsed = -1;
    mNote    = 0;
    mRest    = 1'b1;
  endtask

  task automatic modelEdge();
    if (!rst_n) begin
      modelReset();
    end else begin
      if (!seqIf.run) begin
        mElapsed = -1;
      end else if (mElapsed < 0 || mElapsed == STEP - 1) begin
        mNote    = (int'(mPat[mStep][3:0]) + int'(seqIf.transpose)) % 16;
        mRest    = mPat[mStep][4];
        mElapsed = 0;
      end else begin
        mElapsed++;
        if (mElapsed == STEP - 1)
          mStep = (mStep >= int'(seqIf.last_step)) ? 0 : mStep + 1;
      end
      if (seqIf.wr_en) mPat[seqIf.wr_addr] = seqIf.wr_data;
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    int expGate;
    expGate = (mElapsed >= 0 && mElapsed < GATE && !mRest) ? 1 : 0;
    checks++;
    assert (seqIf.note_out === 4'(mNote)) else begin
      errors++;
      $error("FAIL %s note_out observed=%0d expected=%0d", tag, seqIf.note_out, mNote);
    end
    checks++;
    assert (seqIf.gate_out === 1'(expGate)) else begin
      errors++;
      $error("FAIL %s gate_out observed=%0b expected=%0d", tag, seqIf.gate_out, expGate);
    end
    checks++;
    assert (seqIf.step_idx === 4'(mStep)) else begin
      errors++;
      $error("FAIL %s step_idx observed=%0d expected=%0d", tag, seqIf.step_idx, mStep);
    end
    checks++;
    assert (seqIf.step_strobe === (mElapsed == 0)) else begin
      errors++;
      $error("FAIL %s step_strobe observed=%0b expected=%0b", tag, seqIf.step_strobe, mElapsed == 0);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input logic run, input int lastStep, input int transpose);
    seqIf.run       = run;
    seqIf.last_step = 4'(lastStep);
    seqIf.transpose = 4'(transpose);
  endtask

  // Wait (bounded) until the model says the given step starts on the next edge.
  task automatic waitPending(input int step, input int budget, input string tag);
    int n = 0;
    while (!(mElapsed == STEP - 1 && mStep == step) && n < budget) begin
      cycle(tag);
      n++;
    end
    checks++;
    assert (mElapsed == STEP - 1 && mStep == step) else begin
      errors++;
      $error("FAIL %s timeout observed_cycles=%0d expected_step=%0d", tag, n, step);
    end
  endtask

  task automatic playStep(input string tag, output int note, output int gates,
                          output int strobes, output int stepAtStart);
    gates   = 0;
    strobes = 0;
    note    = 0;
    stepAtStart = 0;
    for (int i = 0; i < STEP; i++) begin
      cycle(tag);
      if (i == 0) begin
        note        = int'(seqIf.note_out);
        stepAtStart = int'(seqIf.step_idx);
      end
      gates   += int'(seqIf.gate_out);
      strobes += int'(seqIf.step_strobe);
    end
  endtask

  initial begin
    int note, gates, strobes, stp;
    int expNotes[5];
    int expGates[3];

    seqIf.wr_en   = 1'b0;
    seqIf.wr_addr = 4'd0;
    seqIf.wr_data = 5'd0;
    applyStimulus(1'b0, 3, 0);
    modelReset();

    cycle("reset");
    cycle("reset");
    rst_n = 1'b1;
    applyStimulus(1'b1, 3, 0);

    // Ascending default pattern over a 4-step loop.
    expNotes = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      playStep("loop4", note, gates, strobes, stp);
      checkValue("loop4_note", note, expNotes[k]);
      checkValue("loop4_gate_cycles", gates, GATE);
      checkValue("loop4_strobes", strobes, 1);
    end

    // Rest step, transpose and transpose wrap.
    seqIf.wr_en = 1'b1; seqIf.wr_addr = 4'd1; seqIf.wr_data = 5'b1_1001;
    cycle("write1");
    seqIf.wr_addr = 4'd2; seqIf.wr_data = 5'b0_1110;
    cycle("write2");
    seqIf.wr_en = 1'b0;
    applyStimulus(1'b1, 2, 3);
    waitPending(0, 100, "wait_loop3");
    expNotes[0] = 3; expNotes[1] = 12; expNotes[2] = 1;
    expGates = '{GATE, 0, GATE};
    for (int k = 0; k < 3; k++) begin
      playStep("transpose", note, gates, strobes, stp);
      checkValue("transpose_note", note, expNotes[k]);
      checkValue("transpose_gate_cycles", gates, expGates[k]);
      checkValue("transpose_strobes", strobes, 1);
    end

    // Shrinking the loop below the playing step wraps to 0.
    applyStimulus(1'b1, 15, 3);
    waitPending(5, 200, "wait_step5");
    cycle("step5_start");
    applyStimulus(1'b1, 2, 3);
    for (int i = 0; i < STEP - 1; i++) cycle("step5_play");
    checkValue("shrink_wrap_step", int'(seqIf.step_idx), 0);
    for (int k = 0; k < 4; k++) begin
      playStep("shrunk_loop", note, gates, strobes, stp);
      checkValue("shrunk_loop_step", stp, (k == 3) ? 0 : k);
    end

    // Pause at tick 2 of step 4, then resume with a full step.
    applyStimulus(1'b1, 15, 3);
    waitPending(4, 200, "wait_step4");
    cycle("step4_start");
    cycle("step4_tick");
    seqIf.run = 1'b0;
    cycle("pause_first");
    checkValue("pause_gate_drop", int'(seqIf.gate_out), 0);
    strobes = 0;
    for (int i = 1; i < 20; i++) begin
      cycle("pause");
      strobes += int'(seqIf.step_strobe);
    end
    checkValue("pause_strobes", strobes, 0);
    checkValue("pause_step_hold", int'(seqIf.step_idx), 4);
    seqIf.run = 1'b1;
    playStep("resume", note, gates, strobes, stp);
    checkValue("resume_step", stp, 4);
    checkValue("resume_note", note, 7);
    checkValue("resume_gate_cycles", gates, GATE);
    checkValue("resume_strobes", strobes, 1);

    // Write to the entry being latched on the same edge.
    applyStimulus(1'b1, 0, 0);
    waitPending(0, 300, "wait_single");
    seqIf.wr_en = 1'b1; seqIf.wr_addr = 4'd0; seqIf.wr_data = 5'b0_0111;
    cycle("rbw_start");
    seqIf.wr_en = 1'b0;
    checkValue("rbw_old_note", int'(seqIf.note_out), 0);
    for (int i = 1; i < STEP; i++) cycle("rbw_hold");
    cycle("rbw_next");
    checkValue("rbw_new_note", int'(seqIf.note_out), 7);
    checkValue("rbw_new_strobe", int'(seqIf.step_strobe), 1);

    // Asynchronous reset while the gate is high.
    #3;
    checkValue("pre_reset_gate", int'(seqIf.gate_out), 1);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkValue("async_gate", int'(seqIf.gate_out), 0);
    checkValue("async_note", int'(seqIf.note_out), 0);
    checkValue("async_step", int'(seqIf.step_idx), 0);
    cycle("reset_held");
    cycle("reset_held");
    rst_n = 1'b1;
    applyStimulus(1'b1, 3, 0);
    playStep("post_reset", note, gates, strobes, stp);
    checkValue("post_reset_note0", note, 0);
    playStep("post_reset", note, gates, strobes, stp);
    checkValue("post_reset_note1", note, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      cycle("random");
      seqIf.run = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 15) == 0) seqIf.last_step = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) seqIf.transpose = 4'($urandom_range(0, 15));
      seqIf.wr_en   = ($urandom_range(0, 3) == 0);
      seqIf.wr_addr = 4'($urandom_range(0, 15));
      seqIf.wr_data = 5'($urandom_range(0, 31));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
